simon_round_controller: RTL and testbench
=========================================

# simon_round_controller

Top-level round sequencer for the Simon Says game. It generates a new 8-bit arrow sequence (four 2-bit directions) for each round from an LFSR and drives the playback engine with it. It then collects the player's four arrow presses and compares them against the sequence, tracking score until the player wins or loses. It sits between the button/key debouncer (inputs) and the playback and display blocks (outputs).

## Interface
Parameters:
- `SEED`, 8'hA5: LFSR reset value; a zero value is replaced by 8'h01.
- `MAX_ROUNDS`, 8: rounds that must be passed to win; legal range 1–15.
- `TIMEOUT`, 28'd150_000_000: cycles allowed between player keys (3 s at 50 MHz).

Ports:
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high; one clock; no other reset.
- `start` in 1: one-cycle pulse that starts or restarts a game.
- `playback_done` in 1: high when the playback engine has finished showing the sequence.
- `key_valid` in 1: one-cycle pulse, already debounced, marking a player key press.
- `key_dir` in 2: direction of the press; sampled only when `key_valid` is high.
- `play_begin` out 1: level; held high to run the playback engine.
- `play_sequence` out 8: sequence for the current round; first arrow in [7:6].
- `input_enable` out 1: high while the block accepts player keys.
- `score` out 4: number of rounds passed.
- `win` out 1: high while in WIN.
- `lose` out 1: high while in LOSE.

## Operation
- States: IDLE, GEN, PLAY, INPUT, ROUND_OK, WIN, LOSE.
- Direction encoding: 0 = up, 1 = down, 2 = left, 3 = right.
- LFSR: 8-bit Galois, steps every cycle, taps 8'hB8. Next value = (q>>1) ^ (q[0] ? 8'hB8 : 0).
- IDLE:
  - `start` → GEN.
  - `score` cleared.
- GEN (one cycle):
  - `play_sequence` ← current LFSR value.
  - The step counter and the compare shadow register are loaded.
  - → PLAY.
- PLAY:
  - `play_begin` = 1.
  - `playback_done` → INPUT.
- INPUT:
  - `input_enable` = 1.
  - The timeout counter counts up.
  - On `key_valid`, `key_dir` is compared with shadow[7:6] and the timeout counter clears.
  - On a match, the shadow shifts left 2 and the step counter increments.
  - A match on the 4th step → ROUND_OK.
  - A mismatch → LOSE.
  - Timeout counter reaching TIMEOUT−1 → LOSE.
- ROUND_OK (one cycle):
  - `score` +1.
  - If the new score equals MAX_ROUNDS → WIN; otherwise → GEN.
- WIN / LOSE:
  - Hold state.
  - `start` → GEN with `score` cleared to 0.
- Ignored inputs:
  - `start` in GEN, PLAY, INPUT or ROUND_OK.
  - `key_valid` outside INPUT, including any key during PLAY.
  - `playback_done` outside PLAY.
- Arithmetic: `score` is 4 bits and cannot wrap because MAX_ROUNDS ≤ 15. The step counter is 2 bits; terminal step = 3.

## Timing
- Reset values:
  - State IDLE.
  - `play_begin`, `input_enable`, `win`, `lose` all 0.
  - `play_sequence` 8'h00, `score` 0.
  - LFSR = SEED.
  - Timeout and step counters 0.
- All outputs are registered and decoded from the state register or held registers; there are no combinational input-to-output paths.
- Latencies:
  - `start` seen at edge t → GEN after t; `play_begin` = 1 and `play_sequence` valid after edge t+1.
  - `playback_done` at edge t → `play_begin` = 0 and `input_enable` = 1 after t.
  - Final correct key at edge t → ROUND_OK after t; `score` updated and `play_begin` = 1 again (next round) after t+2.
  - Wrong key or timeout at edge t → `lose` = 1 and `input_enable` = 0 after t.
- Timeout:
  - Measured from INPUT entry, then from each accepted key.
  - `key_valid` in the same cycle as expiry: the key is evaluated and the timeout is ignored.
- `reset` asserted in any state → IDLE at the next edge; a round in progress is discarded.

## Structure
- Package `simon_pkg` holds:
  - The state enum.
  - The direction constants.
  - LFSR taps 8'hB8.
  - STEPS = 4 and DIR_W = 2.
- Sub-module `sequence_lfsr` (ports: clock, reset, q[7:0]) is the free-running LFSR.
- The FSM, step counter, shadow register, timeout counter and score register live in the top level.

## Test plan
- Reset: assert `reset` mid-INPUT → next cycle state IDLE, all outputs 0, `score` 0.
- Correct round: TIMEOUT=16, MAX_ROUNDS=2, `start` → `play_begin`=1 two cycles later. Pulse `playback_done`, then send the four fields of `play_sequence` MSB-first → `score`=1 and GEN again. Repeat the round → `win`=1, `score`=2.
- Wrong key: sequence 8'b10_01_11_00, keys 2, 1, 0 → `lose`=1 on the cycle after the third key; `score` unchanged.
- Timeout: enter INPUT and send no key for 16 cycles → `lose`=1. Sending a key at cycle 15 instead → no lose.
- Ignored inputs: `key_valid` during PLAY and `start` during INPUT → no state change and the step counter stays 0.
- Restart: `start` in LOSE with `score`=1 → GEN, `score`=0, new `play_sequence` equal to the LFSR value at that edge.

Source files
------------

// File: rtl/simon_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// simon_pkg : shared states, direction codes and LFSR constants
// Revision  : 1.0
// ------------------------------------------------------------------
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GEN      = 3'd1,
    ST_PLAY     = 3'd2,
    ST_INPUT    = 3'd3,
    ST_ROUND_OK = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int         STEPS     = 4;
  localparam int         DIR_W     = 2;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return (q >> 1) ^ (q[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sequence_lfsr.sv
`default_nettype none
// ------------------------------------------------------------------
// sequence_lfsr : free-running 8-bit Galois LFSR, one step per cycle
// Revision      : 1.0
// ------------------------------------------------------------------
module sequence_lfsr
  import simon_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] q
);

  // An all-zero state would lock the LFSR up, so it is never used as a seed.
  localparam logic [7:0] SEED_NZ = (SEED == 8'h00) ? 8'h01 : SEED;

  always_ff @(posedge clock) begin
    if (reset) q <= SEED_NZ;
    else       q <= lfsr_next(q);
  end

endmodule
`default_nettype wire

// File: rtl/simon_round_controller.sv
`default_nettype none
// ------------------------------------------------------------------
// simon_round_controller : Simon Says round sequencer and key checker
// Revision               : 1.0
// ------------------------------------------------------------------
module simon_round_controller
  import simon_pkg::*;
#(
  parameter logic [7:0]  SEED       = 8'hA5,
  parameter int          MAX_ROUNDS = 8,
  parameter logic [27:0] TIMEOUT    = 28'd150_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       playback_done,
  input  logic       key_valid,
  input  logic [1:0] key_dir,
  output logic       play_begin,
  output logic [7:0] play_sequence,
  output logic       input_enable,
  output logic [3:0] score,
  output logic       win,
  output logic       lose
);

  localparam logic [3:0]  MAX_SCORE    = 4'(MAX_ROUNDS);
  localparam logic [27:0] TIMEOUT_LAST = TIMEOUT - 28'd1;
  localparam logic [1:0]  STEP_LAST    = 2'(STEPS - 1);

  state_t      state, state_next;
  logic [7:0]  lfsr_q;
  logic [7:0]  shadow;
  logic [1:0]  step;
  logic [27:0] timer;
  logic        key_match, last_step, timed_out;

  sequence_lfsr #(.SEED(SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign key_match = (key_dir == shadow[7 -: DIR_W]);
  assign last_step = (step == STEP_LAST);
  assign timed_out = (timer == TIMEOUT_LAST);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A key arriving in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (start) state_next = ST_GEN;
      ST_GEN:      state_next = ST_PLAY;
      ST_PLAY:     if (playback_done) state_next = ST_INPUT;
      ST_INPUT: begin
        if (key_valid) begin
          if (!key_match)     state_next = ST_LOSE;
          else if (last_step) state_next = ST_ROUND_OK;
        end else if (timed_out) begin
          state_next = ST_LOSE;
        end
      end
      ST_ROUND_OK: state_next = (score + 4'd1 == MAX_SCORE) ? ST_WIN : ST_GEN;
      ST_WIN,
      ST_LOSE:     if (start) state_next = ST_GEN;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      play_sequence <= 8'h00;
      shadow        <= 8'h00;
      step          <= 2'd0;
      timer         <= 28'd0;
      score         <= 4'd0;
    end else begin
      timer <= 28'd0;
      case (state)
        ST_IDLE: score <= 4'd0;
        ST_GEN: begin
          play_sequence <= lfsr_q;
          shadow        <= lfsr_q;
          step          <= 2'd0;
        end
        ST_INPUT: begin
          if (key_valid) begin
            if (key_match) begin
              shadow <= shadow << DIR_W;
              step   <= step + 2'd1;
            end
          end else begin
            timer <= timer + 28'd1;
          end
        end
        ST_ROUND_OK: score <= score + 4'd1;
        ST_WIN,
        ST_LOSE: if (start) score <= 4'd0;
        default: ;
      endcase
    end
  end

  assign play_begin   = (state == ST_PLAY);
  assign input_enable = (state == ST_INPUT);
  assign win          = (state == ST_WIN);
  assign lose         = (state == ST_LOSE);

endmodule
`default_nettype wire

// File: tb/tb_simon_round_controller.sv
`default_nettype none
// Randomized game-level bench for simon_round_controller; inputs change on
// the falling edge, outputs are checked on the following falling edge.
module tb_simon_round_controller;

  localparam logic [7:0] SEED       = 8'hA5;
  localparam int         MAX_ROUNDS = 2;
  localparam int         TIMEOUT    = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       playback_done = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_dir = 2'd0;
  logic       play_begin, input_enable, win, lose;
  logic [7:0] play_sequence;
  logic [3:0] score;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_lfsr;
  logic [7:0] lfsr_at_edge;
  logic [7:0] cur_seq;
  int         exp_score;

  always #5 clock = ~clock;

  simon_round_controller #(
    .SEED       (SEED),
    .MAX_ROUNDS (MAX_ROUNDS),
    .TIMEOUT    (28'(TIMEOUT))
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .playback_done (playback_done),
    .key_valid     (key_valid),
    .key_dir       (key_dir),
    .play_begin    (play_begin),
    .play_sequence (play_sequence),
    .input_enable  (input_enable),
    .score         (score),
    .win           (win),
    .lose          (lose)
  );

  // Reference LFSR; lfsr_at_edge is the value the design saw at the last edge.
  always @(posedge clock) begin
    lfsr_at_edge = ref_lfsr;
    if (reset) ref_lfsr = SEED;
    else       ref_lfsr = (ref_lfsr / 2) ^ ((ref_lfsr % 2 == 1) ? 8'hB8 : 8'h00);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic pb, input logic ie,
                            input logic w, input logic l);
    check({tag, ".play_begin"},   32'(play_begin),   32'(pb));
    check({tag, ".input_enable"}, 32'(input_enable), 32'(ie));
    check({tag, ".win"},          32'(win),          32'(w));
    check({tag, ".lose"},         32'(lose),         32'(l));
    check({tag, ".score"},        32'(score),        32'(exp_score));
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // Called on the falling edge right after the design entered GEN.
  task automatic gen_to_play(input string tag);
    check_outs({tag, ".gen"}, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    check_outs({tag, ".play"}, 1'b1, 1'b0, 1'b0, 1'b0);
    check({tag, ".play_sequence"}, 32'(play_sequence), 32'(lfsr_at_edge));
    cur_seq = lfsr_at_edge;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    cyc();
    start = 1'b0;
    exp_score = 0;
    gen_to_play(tag);
  endtask

  // Spurious keys during playback must be ignored, then enter INPUT.
  task automatic do_play();
    int n;
    n = $urandom_range(0, 4);
    repeat (n) begin
      key_valid = 1'($urandom_range(0, 1));
      key_dir   = 2'($urandom);
      cyc();
      key_valid = 1'b0;
      check_outs("play_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    playback_done = 1'b1;
    cyc();
    playback_done = 1'b0;
    check_outs("input_entry", 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // wrong_idx < 0 plays a full correct round; max_gap waits TIMEOUT-1 idle cycles per key.
  task automatic do_input(input int wrong_idx, input bit max_gap);
    int         gap;
    logic [1:0] want;
    for (int i = 0; i < 4; i++) begin
      gap = max_gap ? TIMEOUT - 1 : int'($urandom_range(0, TIMEOUT - 2));
      repeat (gap) begin
        start = ($urandom_range(0, 5) == 0);
        cyc();
        start = 1'b0;
      end
      check_outs("key_gap", 1'b0, 1'b1, 1'b0, 1'b0);
      want      = cur_seq[7 - 2*i -: 2];
      key_valid = 1'b1;
      key_dir   = (i == wrong_idx) ? (want ^ 2'($urandom_range(1, 3))) : want;
      cyc();
      key_valid = 1'b0;
      if (i == wrong_idx) begin
        check_outs("wrong_key", 1'b0, 1'b0, 1'b0, 1'b1);
        return;
      end
      if (i < 3) check_outs("good_key", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check_outs("round_ok", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    exp_score++;
    if (exp_score == MAX_ROUNDS) check_outs("win", 1'b0, 1'b0, 1'b1, 1'b0);
    else                         gen_to_play("next_round");
  endtask

  task automatic do_timeout();
    repeat (TIMEOUT - 1) cyc();
    check_outs("pre_timeout", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    check_outs("timeout", 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int n;
    int mode;
    bit done;
    exp_score = 0;
    repeat (3) cyc();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.play_sequence", 32'(play_sequence), 32'h0);
    reset = 1'b0;

    n = $urandom_range(1, 5);
    repeat (n) begin
      key_valid     = 1'($urandom_range(0, 1));
      playback_done = 1'($urandom_range(0, 1));
      cyc();
      key_valid     = 1'b0;
      playback_done = 1'b0;
      check_outs("idle_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Full winning game.
    do_start("game1");
    for (int r = 0; r < MAX_ROUNDS; r++) begin
      do_play();
      do_input(-1, 1'b0);
    end
    repeat (3) begin
      key_valid     = 1'b1;
      playback_done = 1'b1;
      cyc();
      key_valid     = 1'b0;
      playback_done = 1'b0;
      check_outs("win_hold", 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Restart from WIN; first round keys arrive exactly at the expiry cycle.
    do_start("restart_win");
    do_play();
    do_input(-1, 1'b1);
    do_play();
    do_input(int'($urandom_range(0, 3)), 1'b0);
    repeat (2) begin
      cyc();
      check_outs("lose_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Restart from LOSE with score 1, then lose by timeout.
    do_start("restart_lose");
    do_play();
    do_timeout();

    // Reset in the middle of INPUT.
    do_start("pre_reset");
    do_play();
    key_valid = 1'b1;
    key_dir   = cur_seq[7:6];
    cyc();
    key_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_score = 0;
    check_outs("reset_mid_input", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_mid_input.play_sequence", 32'(play_sequence), 32'h0);

    // Randomized games.
    for (int g = 0; g < 6; g++) begin
      done = 1'b0;
      do_start("rand_game");
      while (!done) begin
        do_play();
        mode = $urandom_range(0, 5);
        if (mode == 0) begin
          do_timeout();
          done = 1'b1;
        end else if (mode == 1) begin
          do_input(int'($urandom_range(0, 3)), 1'b0);
          done = 1'b1;
        end else begin
          do_input(-1, ($urandom_range(0, 3) == 0));
          done = (exp_score == MAX_ROUNDS);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
